// File: rtl/axilite_regbank_if.sv
// AXI4-Lite bus bundle for the register bank: the five channels grouped
// into one interface, with master and slave views.
interface axilite_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axilite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS byte-writable registers, read-only
// slots sourced from reg_in, SLVERR on bad accesses, per-register strobes.
module axilite_regbank #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           axis_aclk,
  input  logic                           axis_areset,
  axilite_regbank_if.slave               axis,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [NUM_REGS-1:0]            rd_pulse
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH = ADDR_WIDTH - LSB;

  logic                           rst_done;
  logic                           aw_full;
  logic [IDX_WIDTH-1:0]           aw_idx;
  logic                           w_full;
  logic [DATA_WIDTH-1:0]          w_data;
  logic [STRB_WIDTH-1:0]          w_strb;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs;
  logic                           aw_hs;
  logic                           w_hs;
  logic                           ar_hs;
  logic                           commit;
  logic [IDX_WIDTH-1:0]           ar_idx;
  logic [NUM_REGS-1:0]            wr_hit;
  logic [NUM_REGS-1:0]            rd_sel;
  logic                           wr_ok;
  logic                           rd_ok;
  logic [DATA_WIDTH-1:0]          rd_mux;
  logic                           unused_ok;

  // Readies stay low until one clock after reset has been released.
  assign axis.awready = rst_done && !aw_full;
  assign axis.wready  = rst_done && !w_full;
  assign axis.arready = rst_done && !axis.rvalid;

  assign aw_hs  = axis.awvalid && axis.awready;
  assign w_hs   = axis.wvalid && axis.wready;
  assign ar_hs  = axis.arvalid && axis.arready;
  assign commit = aw_full && w_full && (!axis.bvalid || axis.bready);
  assign ar_idx = axis.araddr[ADDR_WIDTH-1:LSB];
  assign wr_ok  = |wr_hit;
  assign rd_ok  = |rd_sel;
  assign reg_out = regs;

  // Protection bits and sub-word address bits carry no meaning here.
  assign unused_ok = ^{axis.awprot, axis.arprot, axis.awaddr[LSB-1:0],
                       axis.araddr[LSB-1:0], reg_in};

  // Decode the buffered write index and the incoming read index.
  always_comb begin
    wr_hit = '0;
    rd_sel = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(aw_idx) == i && !RO_MASK[i]) wr_hit[i] = 1'b1;
      if (int'(ar_idx) == i) begin
        rd_sel[i] = 1'b1;
        rd_mux = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH]
                            : regs[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Marks the first clock after reset release so readies open one cycle late.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) rst_done <= 1'b0;
    else             rst_done <= 1'b1;
  end

  // One-entry AW and W holding buffers, filled independently, emptied on commit.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      aw_full <= 1'b0;
      aw_idx  <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= axis.awaddr[ADDR_WIDTH-1:LSB];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= axis.wdata;
        w_strb <= axis.wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  // Commit a buffered write: byte-merge into the register, raise the response and strobe.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      regs        <= '0;
      axis.bvalid <= 1'b0;
      axis.bresp  <= 2'b00;
      wr_pulse    <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        axis.bvalid <= 1'b1;
        axis.bresp  <= wr_ok ? 2'b00 : 2'b10;
        wr_pulse    <= wr_hit;
        for (int i = 0; i < NUM_REGS; i++) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wr_hit[i] && w_strb[b])
              regs[i*DATA_WIDTH + b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
      end else if (axis.bready) begin
        axis.bvalid <= 1'b0;
      end
    end
  end

  // Register read data on the AR handshake and hold it until the R handshake.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      axis.rvalid <= 1'b0;
      axis.rdata  <= '0;
      axis.rresp  <= 2'b00;
      rd_pulse    <= '0;
    end else begin
      rd_pulse <= '0;
      if (ar_hs) begin
        axis.rvalid <= 1'b1;
        axis.rdata  <= rd_ok ? rd_mux : '0;
        axis.rresp  <= rd_ok ? 2'b00 : 2'b10;
        rd_pulse    <= rd_sel;
      end else if (axis.rready) begin
        axis.rvalid <= 1'b0;
      end
    end
  end
endmodule
